// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared types and default widths for the fetch/sequencing logic
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int          PC_W       = 16;
    localparam int          TGT_W      = 8;
    localparam int          CNT_W      = 16;
    localparam logic [15:0] START_ADDR = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } pcseq_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_if.sv
// ============================================================================
// pc_sequencer_if : control/status bundle between the harness and the sequencer
// Optional ports under PC_SEQ_BRANCH_STATS_EN. Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface pc_sequencer_if #(
    parameter int PC_W  = cpu_pkg::PC_W,
    parameter int TGT_W = cpu_pkg::TGT_W,
    parameter int CNT_W = cpu_pkg::CNT_W
);

    logic             start;
    logic             stall;
    logic             beq;
    logic             blt;
    logic             equal;
    logic             lessthan;
    logic [TGT_W-1:0] target;
    logic             halt;
    logic [PC_W-1:0]  pc_out;
    logic             fetch_en;
    logic             flush;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cycle_count;
`ifdef PC_SEQ_BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_count;
    logic [PC_W-1:0]  last_target;
`endif

    modport master (
`ifdef PC_SEQ_BRANCH_STATS_EN
        input  taken_count, last_target,
`endif
        output start, stall, beq, blt, equal, lessthan, target, halt,
        input  pc_out, fetch_en, flush, busy, done, cycle_count
    );

    modport slave (
`ifdef PC_SEQ_BRANCH_STATS_EN
        output taken_count, last_target,
`endif
        input  start, stall, beq, blt, equal, lessthan, target, halt,
        output pc_out, fetch_en, flush, busy, done, cycle_count
    );

endinterface

`default_nettype wire

// File: rtl/pc_sequencer_branch_decide.sv
// ============================================================================
// branch_decide : combinational branch-taken resolution from opcode/ALU flags
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module branch_decide (
    input  wire logic beq,
    input  wire logic blt,
    input  wire logic equal,
    input  wire logic lessthan,
    output logic      taken
);

    // beq together with blt is the unconditional-jump encoding
    assign taken = (beq && blt) || (beq && equal) || (blt && lessthan);

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer : program counter, fetch enable, branch flush and cycle count
// Optional branch statistics under PC_SEQ_BRANCH_STATS_EN. Rev 1.0
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter int              PC_W       = cpu_pkg::PC_W,
    parameter int              TGT_W      = cpu_pkg::TGT_W,
    parameter int              CNT_W      = cpu_pkg::CNT_W,
    parameter logic [PC_W-1:0] START_ADDR = PC_W'(cpu_pkg::START_ADDR)
) (
    input  wire logic      clk,
    input  wire logic      reset_n,
    pc_sequencer_if.slave  bus
);

    import cpu_pkg::pcseq_state_t;
    import cpu_pkg::IDLE;
    import cpu_pkg::RUN;
    import cpu_pkg::FLUSH;
    import cpu_pkg::HALT;

    pcseq_state_t     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             fetch_en_q, fetch_en_d;
    logic             flush_q, flush_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef PC_SEQ_BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [PC_W-1:0]  last_tgt_q, last_tgt_d;
`endif

    logic             taken_raw;
    logic             taken_acc;
    logic [PC_W-1:0]  tgt_ext;
    logic [CNT_W-1:0] cnt_inc;

    branch_decide u_branch_decide (
        .beq      (bus.beq),
        .blt      (bus.blt),
        .equal    (bus.equal),
        .lessthan (bus.lessthan),
        .taken    (taken_raw)
    );

    assign taken_acc = (state_q == RUN) && !bus.stall && !bus.halt && taken_raw;
    assign tgt_ext   = {{(PC_W-TGT_W){1'b0}}, bus.target};
    assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = RUN;
            end
            RUN: begin
                if (bus.stall)      state_d = RUN;
                else if (bus.halt)  state_d = HALT;
                else if (taken_raw) state_d = FLUSH;
                else                state_d = RUN;
            end
            FLUSH: begin
                // a stalled bubble keeps squashing until it can advance
                if (!bus.stall) state_d = RUN;
            end
            HALT: begin
                if (bus.start) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        fetch_en_d = 1'b0;
        flush_d    = 1'b0;
        busy_d     = (state_d == RUN) || (state_d == FLUSH);
        done_d     = (state_d == HALT);
`ifdef PC_SEQ_BRANCH_STATS_EN
        taken_cnt_d = taken_cnt_q;
        last_tgt_d  = last_tgt_q;
`endif
        case (state_q)
            IDLE, HALT: begin
                if (bus.start) begin
                    pc_d       = START_ADDR;
                    cnt_d      = '0;
                    fetch_en_d = 1'b1;
`ifdef PC_SEQ_BRANCH_STATS_EN
                    taken_cnt_d = '0;
`endif
                end
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (bus.stall) begin
                    fetch_en_d = 1'b0;
                end else if (bus.halt) begin
                    fetch_en_d = 1'b0;
                end else if (taken_raw) begin
                    pc_d       = tgt_ext;
                    flush_d    = 1'b1;
                    fetch_en_d = 1'b1;
                end else begin
                    pc_d       = pc_q + PC_W'(1);
                    fetch_en_d = 1'b1;
                end
            end
            FLUSH: begin
                cnt_d = cnt_inc;
                if (bus.stall) begin
                    flush_d = 1'b1;
                end else begin
                    pc_d       = pc_q + PC_W'(1);
                    fetch_en_d = 1'b1;
                end
            end
            default: begin
                pc_d = START_ADDR;
            end
        endcase
`ifdef PC_SEQ_BRANCH_STATS_EN
        if (taken_acc) begin
            last_tgt_d = tgt_ext;
            if (taken_cnt_q != {CNT_W{1'b1}}) taken_cnt_d = taken_cnt_q + CNT_W'(1);
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= START_ADDR;
            fetch_en_q <= 1'b0;
            flush_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            fetch_en_q <= fetch_en_d;
            flush_q    <= flush_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef PC_SEQ_BRANCH_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            taken_cnt_q <= '0;
            last_tgt_q  <= START_ADDR;
        end else begin
            taken_cnt_q <= taken_cnt_d;
            last_tgt_q  <= last_tgt_d;
        end
    end

    assign bus.taken_count = taken_cnt_q;
    assign bus.last_target = last_tgt_q;
`else
    logic unused_taken_acc;
    assign unused_taken_acc = taken_acc;
`endif

    assign bus.pc_out      = pc_q;
    assign bus.fetch_en    = fetch_en_q;
    assign bus.flush       = flush_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.cycle_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// tb_pc_sequencer : directed vector table plus wrap/saturation and async-reset
// sequences for pc_sequencer. Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    pc_sequencer_if bus_if ();

    pc_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    typedef struct {
        logic        start, stall, halt, beq, blt, equal, lessthan;
        logic [7:0]  target;
        logic [15:0] e_pc;
        logic        e_fe, e_fl, e_busy, e_done;
        logic [15:0] e_cnt;
    } vec_t;

    int n_err   = 0;
    int n_check = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_check++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] pc, input logic fe,
                           input logic fl, input logic bz, input logic dn, input logic [15:0] cnt);
        chk({tag, ".pc_out"},      32'(bus_if.pc_out),      32'(pc));
        chk({tag, ".fetch_en"},    32'(bus_if.fetch_en),    32'(fe));
        chk({tag, ".flush"},       32'(bus_if.flush),       32'(fl));
        chk({tag, ".busy"},        32'(bus_if.busy),        32'(bz));
        chk({tag, ".done"},        32'(bus_if.done),        32'(dn));
        chk({tag, ".cycle_count"}, 32'(bus_if.cycle_count), 32'(cnt));
    endtask

    function automatic vec_t mk(input logic st, input logic sl, input logic hl, input logic bq,
                                input logic bl, input logic eq, input logic lt, input logic [7:0] tg,
                                input logic [15:0] pc, input logic fe, input logic fl,
                                input logic bz, input logic dn, input logic [15:0] cnt);
        vec_t v;
        v.start = st; v.stall = sl; v.halt = hl; v.beq = bq; v.blt = bl;
        v.equal = eq; v.lessthan = lt; v.target = tg;
        v.e_pc = pc; v.e_fe = fe; v.e_fl = fl; v.e_busy = bz; v.e_done = dn; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus_if.start    = v.start;
        bus_if.stall    = v.stall;
        bus_if.halt     = v.halt;
        bus_if.beq      = v.beq;
        bus_if.blt      = v.blt;
        bus_if.equal    = v.equal;
        bus_if.lessthan = v.lessthan;
        bus_if.target   = v.target;
    endtask

    vec_t vecs[25];
    vec_t idle_v;
    bit   found;

    initial begin
        //             st sl hl bq bl eq lt tgt      pc        fe fl bz dn cnt
        vecs[0]  = mk(0, 0, 0, 1, 1, 0, 0, 8'h33, 16'h0000, 0, 0, 0, 0, 16'd0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 1, 0, 1, 0, 16'd0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0001, 1, 0, 1, 0, 16'd1);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0002, 1, 0, 1, 0, 16'd2);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0003, 1, 0, 1, 0, 16'd3);
        vecs[5]  = mk(0, 0, 0, 1, 0, 1, 0, 8'h40, 16'h0040, 1, 1, 1, 0, 16'd4);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0041, 1, 0, 1, 0, 16'd5);
        vecs[7]  = mk(0, 0, 0, 1, 0, 0, 1, 8'h99, 16'h0042, 1, 0, 1, 0, 16'd6);
        vecs[8]  = mk(0, 0, 0, 0, 1, 0, 1, 8'h05, 16'h0005, 1, 1, 1, 0, 16'd7);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0006, 1, 0, 1, 0, 16'd8);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0007, 1, 0, 1, 0, 16'd9);
        vecs[11] = mk(0, 1, 0, 1, 1, 0, 0, 8'h20, 16'h0007, 0, 0, 1, 0, 16'd10);
        vecs[12] = mk(0, 1, 0, 1, 1, 0, 0, 8'h20, 16'h0007, 0, 0, 1, 0, 16'd11);
        vecs[13] = mk(0, 0, 0, 1, 1, 0, 0, 8'h20, 16'h0020, 1, 1, 1, 0, 16'd12);
        vecs[14] = mk(0, 1, 1, 0, 0, 0, 0, 8'h00, 16'h0020, 0, 1, 1, 0, 16'd13);
        vecs[15] = mk(0, 0, 1, 0, 0, 0, 0, 8'h00, 16'h0021, 1, 0, 1, 0, 16'd14);
        vecs[16] = mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0022, 1, 0, 1, 0, 16'd15);
        vecs[17] = mk(0, 0, 0, 0, 1, 1, 0, 8'h55, 16'h0023, 1, 0, 1, 0, 16'd16);
        vecs[18] = mk(0, 0, 0, 1, 0, 1, 0, 8'h08, 16'h0008, 1, 1, 1, 0, 16'd17);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0009, 1, 0, 1, 0, 16'd18);
        vecs[20] = mk(0, 0, 1, 0, 1, 0, 1, 8'h77, 16'h0009, 0, 0, 0, 1, 16'd19);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0009, 0, 0, 0, 1, 16'd19);
        vecs[22] = mk(0, 0, 0, 1, 1, 0, 0, 8'h44, 16'h0009, 0, 0, 0, 1, 16'd19);
        vecs[23] = mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 1, 0, 1, 0, 16'd0);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0001, 1, 0, 1, 0, 16'd1);
        idle_v   = mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'd0);

        reset_n = 1'b0;
        drive(idle_v);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 16'h0000, 0, 0, 0, 0, 16'd0);

        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_fe, vecs[i].e_fl,
                    vecs[i].e_busy, vecs[i].e_done, vecs[i].e_cnt);
        end

        // Free-run to the top of the address space: pc and count advance together
        @(negedge clk);
        drive(idle_v);
        found = 1'b0;
        for (int c = 0; c < 70000 && !found; c++) begin
            @(posedge clk);
            #1;
            if (bus_if.pc_out == 16'hFFFE) found = 1'b1;
        end
        n_check++;
        if (!found) begin
            n_err++;
            $display("FAIL wrap_reach: got pc_out %0h expected fffe within bound", bus_if.pc_out);
        end
        chk("wrap.cnt_fffe", 32'(bus_if.cycle_count), 32'h0000FFFE);
        @(posedge clk); #1;
        chk_all("wrap0", 16'hFFFF, 1, 0, 1, 0, 16'hFFFF);
        @(posedge clk); #1;
        chk_all("wrap1", 16'h0000, 1, 0, 1, 0, 16'hFFFF);
        @(posedge clk); #1;
        chk_all("wrap2", 16'h0001, 1, 0, 1, 0, 16'hFFFF);

        // Enter FLUSH, then pull reset between clock edges
        @(negedge clk);
        bus_if.beq    = 1'b1;
        bus_if.equal  = 1'b1;
        bus_if.target = 8'h10;
        @(posedge clk); #1;
        chk("aflush.flush", 32'(bus_if.flush), 32'd1);
        chk("aflush.pc_out", 32'(bus_if.pc_out), 32'h0010);
        drive(idle_v);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("async_rst", 16'h0000, 0, 0, 0, 0, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk_all("post_rst", 16'h0000, 0, 0, 0, 0, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_check);
        $finish;
    end

endmodule

`default_nettype wire
